// File: rtl/sram_macro_ctrl_pkg.sv
// Shared types and helpers for the SRAM macro controller.
//   state_e      : controller FSM states (BIST states only reachable when
//                  SRAM_MACRO_CTRL_BIST_EN is defined)
//   BIST_PAT     : byte XORed into the address to form the self-test pattern
//   bist_pattern : self-test data word for a given address (up to 32 bits)
package sram_macro_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      SENSE,
      CAPTURE,
      RESP,
      BIST_WR,
      BIST_RD
   } state_e;

   localparam logic [7:0] BIST_PAT = 8'hA5;

   // Pattern byte is replicated so wider macros still see a non-trivial word;
   // callers truncate to their data width.
   function automatic logic [31:0] bist_pattern(input logic [31:0] addr);
      return addr ^ {4{BIST_PAT}};
   endfunction

endpackage

// File: rtl/sram_macro_ctrl_if.sv
// Request/response bus between the datapath (master) and one SRAM macro
// controller (slave).
//   req_valid/req_ready/req_we/req_addr/req_wdata : request channel
//   resp_valid/resp_ready/resp_rdata/resp_err     : read response channel
interface sram_macro_ctrl_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 12
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              resp_valid;
   logic              resp_ready;
   logic [DATA_W-1:0] resp_rdata;
   logic              resp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/sram_macro_ctrl_bist.sv
// Self-test address sweeper and read-back comparator (only instantiated when
// SRAM_MACRO_CTRL_BIST_EN is defined).
//   clk, resetn : clock, synchronous active-low reset
//   start_i     : restart sweep at address 0 and clear the fail flag
//   rewind_i    : return to address 0 (write pass -> read pass)
//   inc_i       : advance to the next address
//   cmp_i       : compare rdata_i with the pattern of the current address
//   addr_o      : current sweep address (registered)
//   pat_o       : expected/written data for addr_o
//   last_o      : addr_o is DEPTH-1
//   fail_o      : sticky mismatch flag
module sram_macro_ctrl_bist
   import sram_macro_ctrl_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 12,
   parameter int DEPTH  = 4096
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              start_i,
   input  logic              rewind_i,
   input  logic              inc_i,
   input  logic              cmp_i,
   input  logic [DATA_W-1:0] rdata_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic [DATA_W-1:0] pat_o,
   output logic              last_o,
   output logic              fail_o
);
   logic [ADDR_W-1:0] addr_q;
   logic              fail_q;

   assign pat_o  = DATA_W'(bist_pattern(32'(addr_q)));
   assign last_o = ({1'b0, addr_q} == (ADDR_W+1)'(DEPTH - 1));
   assign addr_o = addr_q;
   assign fail_o = fail_q;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         addr_q <= '0;
         fail_q <= 1'b0;
      end else if (start_i) begin
         addr_q <= '0;
         fail_q <= 1'b0;
      end else begin
         if (rewind_i)
            addr_q <= '0;
         else if (inc_i)
            addr_q <= addr_q + 1'b1;
         if (cmp_i && (rdata_i != pat_o))
            fail_q <= 1'b1;
      end
   end
endmodule

// File: rtl/sram_macro_ctrl.sv
// Request/response controller for one single-port compiled SRAM macro.
// Sequences write_en / sense_en around latched address and data, captures
// dout on the edge that closes the sense window, and holds the read response
// until the consumer takes it. Out-of-range addresses never reach the macro.
//   clk, resetn     : clock, synchronous active-low reset
//   bus (slave)     : request/response channel
//   wr_err_o        : one-cycle pulse, out-of-range write dropped
//   mem_addr_o/mem_din_o/mem_dout_i/mem_write_en_o/mem_sense_en_o : macro pins
// Optional: SRAM_MACRO_CTRL_BIST_EN adds bist_start_i, bist_busy_o,
// bist_done_o, bist_fail_o and a write-then-read-back self-test sweep.
//
// state    | meaning
// IDLE     | waiting for a request (or self-test start)
// WRITE    | write_en high for WR_CYCLES (held low for a dropped write)
// SENSE    | sense_en high for SENSE_CYCLES; dout captured on the last edge
// CAPTURE  | captured data settles, resp_valid raised next edge
// RESP     | response held until resp_ready
// BIST_WR  | self-test write pass (write_en high = access, low = gap)
// BIST_RD  | self-test read pass  (sense_en high = access, low = gap)
module sram_macro_ctrl
   import sram_macro_ctrl_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int ADDR_W       = 12,
   parameter int DEPTH        = 4096,
   parameter int WR_CYCLES    = 1,
   parameter int SENSE_CYCLES = 2
) (
   input  logic              clk,
   input  logic              resetn,
   sram_macro_ctrl_if.slave  bus,
   output logic              wr_err_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_din_o,
   input  logic [DATA_W-1:0] mem_dout_i,
   output logic              mem_write_en_o,
   output logic              mem_sense_en_o
`ifdef SRAM_MACRO_CTRL_BIST_EN
   ,
   input  logic              bist_start_i,
   output logic              bist_busy_o,
   output logic              bist_done_o,
   output logic              bist_fail_o
`endif
);
   localparam int CNT_MAX = (WR_CYCLES > SENSE_CYCLES) ? WR_CYCLES : SENSE_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] WR_LOAD    = CNT_W'(WR_CYCLES - 1);
   localparam logic [CNT_W-1:0] SENSE_LOAD = CNT_W'(SENSE_CYCLES - 1);

   state_e            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] din_q;
   logic              we_en_q;
   logic              se_en_q;
   logic              ready_q;
   logic              resp_valid_q;
   logic [DATA_W-1:0] rdata_q;
   logic              resp_err_q;
   logic              wr_err_q;
   logic              req_legal;
   logic              accept;

   assign req_legal = ({1'b0, bus.req_addr} < (ADDR_W+1)'(DEPTH));
   assign accept    = (state_q == IDLE) && bus.req_valid && ready_q;

`ifdef SRAM_MACRO_CTRL_BIST_EN
   logic              busy_q;
   logic              done_q;
   logic              bist_go;
   logic              bist_rewind;
   logic              bist_inc;
   logic              bist_cmp;
   logic              bist_last;
   logic              bist_fail;
   logic [ADDR_W-1:0] bist_addr;
   logic [DATA_W-1:0] bist_pat;

   // A request accepted in the same cycle wins over a self-test start.
   assign bist_go     = bist_start_i && (state_q == IDLE) && !resp_valid_q && !accept;
   assign bist_rewind = (state_q == BIST_WR) && !we_en_q && bist_last;
   assign bist_inc    = ((state_q == BIST_WR) && !we_en_q && !bist_last) ||
                        ((state_q == BIST_RD) && !se_en_q);
   assign bist_cmp    = (state_q == BIST_RD) && se_en_q && (cnt_q == '0);

   sram_macro_ctrl_bist #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_bist (
      .clk      (clk),
      .resetn   (resetn),
      .start_i  (bist_go),
      .rewind_i (bist_rewind),
      .inc_i    (bist_inc),
      .cmp_i    (bist_cmp),
      .rdata_i  (mem_dout_i),
      .addr_o   (bist_addr),
      .pat_o    (bist_pat),
      .last_o   (bist_last),
      .fail_o   (bist_fail)
   );

   assign mem_addr_o  = busy_q ? bist_addr : addr_q;
   assign mem_din_o   = busy_q ? bist_pat  : din_q;
   assign bist_busy_o = busy_q;
   assign bist_done_o = done_q;
   assign bist_fail_o = bist_fail;
`else
   assign mem_addr_o = addr_q;
   assign mem_din_o  = din_q;
`endif

   assign mem_write_en_o = we_en_q;
   assign mem_sense_en_o = se_en_q;
   assign wr_err_o       = wr_err_q;
   assign bus.req_ready  = ready_q;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_rdata = rdata_q;
   assign bus.resp_err   = resp_err_q;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         addr_q       <= '0;
         din_q        <= '0;
         we_en_q      <= 1'b0;
         se_en_q      <= 1'b0;
         ready_q      <= 1'b0;
         resp_valid_q <= 1'b0;
         rdata_q      <= '0;
         resp_err_q   <= 1'b0;
         wr_err_q     <= 1'b0;
`ifdef SRAM_MACRO_CTRL_BIST_EN
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
`endif
      end else begin
         wr_err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               ready_q <= 1'b1;
               if (accept) begin
                  ready_q <= 1'b0;
                  if (bus.req_we) begin
                     state_q <= WRITE;
                     cnt_q   <= WR_LOAD;
                     // Dropped writes keep the pins untouched.
                     if (req_legal) begin
                        addr_q  <= bus.req_addr;
                        din_q   <= bus.req_wdata;
                        we_en_q <= 1'b1;
                     end else begin
                        wr_err_q <= 1'b1;
                     end
                  end else if (req_legal) begin
                     state_q <= SENSE;
                     cnt_q   <= SENSE_LOAD;
                     addr_q  <= bus.req_addr;
                     se_en_q <= 1'b1;
                  end else begin
                     state_q      <= RESP;
                     resp_valid_q <= 1'b1;
                     rdata_q      <= '0;
                     resp_err_q   <= 1'b1;
                  end
               end
`ifdef SRAM_MACRO_CTRL_BIST_EN
               else if (bist_go) begin
                  ready_q <= 1'b0;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
                  state_q <= BIST_WR;
                  we_en_q <= 1'b1;
                  cnt_q   <= WR_LOAD;
               end
`endif
            end
            WRITE: begin
               if (cnt_q == '0) begin
                  we_en_q <= 1'b0;
                  state_q <= IDLE;
                  ready_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            SENSE: begin
               if (cnt_q == '0) begin
                  se_en_q <= 1'b0;
                  rdata_q <= mem_dout_i;
                  state_q <= CAPTURE;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            CAPTURE: begin
               resp_valid_q <= 1'b1;
               resp_err_q   <= 1'b0;
               state_q      <= RESP;
            end
            RESP: begin
               if (bus.resp_ready) begin
                  resp_valid_q <= 1'b0;
                  resp_err_q   <= 1'b0;
                  rdata_q      <= '0;
                  state_q      <= IDLE;
                  ready_q      <= 1'b1;
               end
            end
`ifdef SRAM_MACRO_CTRL_BIST_EN
            BIST_WR: begin
               if (we_en_q) begin
                  if (cnt_q == '0) we_en_q <= 1'b0;
                  else             cnt_q   <= cnt_q - 1'b1;
               end else if (bist_last) begin
                  state_q <= BIST_RD;
                  se_en_q <= 1'b1;
                  cnt_q   <= SENSE_LOAD;
               end else begin
                  we_en_q <= 1'b1;
                  cnt_q   <= WR_LOAD;
               end
            end
            BIST_RD: begin
               if (se_en_q) begin
                  if (cnt_q == '0) begin
                     se_en_q <= 1'b0;
                     if (bist_last) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        ready_q <= 1'b1;
                     end
                  end else begin
                     cnt_q <= cnt_q - 1'b1;
                  end
               end else begin
                  se_en_q <= 1'b1;
                  cnt_q   <= SENSE_LOAD;
               end
            end
`endif
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule
